// File: rtl/pad_sensor_pkg.sv
// Shared field layout, save FSM states and packing helpers for the pad sensor front end.
package pad_sensor_pkg;

    localparam int FIELD_W  = 7;
    localparam int PAD0_LSB = 0;
    localparam int PAD1_LSB = 7;
    localparam int PAD2_LSB = 14;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        RELEASE  = 2'd2
    } save_state_e;

    function automatic logic [31:0] pack_pads(
        input logic [FIELD_W-1:0] f0,
        input logic [FIELD_W-1:0] f1,
        input logic [FIELD_W-1:0] f2
    );
        return {11'b0, f2, f1, f0};
    endfunction

    function automatic logic fields_all_zero(input logic [31:0] word);
        return (word[PAD2_LSB+FIELD_W-1:PAD0_LSB] == '0);
    endfunction

endpackage

// File: rtl/pad_sensor_frontend_if.sv
// Raw pad samples, vsync and save handshake in; frame-aligned sensor word and save request out.
interface pad_sensor_frontend_if;
    import pad_sensor_pkg::*;

    logic               raw_valid;
    logic [FIELD_W-1:0] raw_pad0;
    logic [FIELD_W-1:0] raw_pad1;
    logic [FIELD_W-1:0] raw_pad2;
    logic               vs_n;
    logic               save_ack;
    logic [31:0]        sensor_input;
    logic [31:0]        sensor_input_to_save;
    logic [31:0]        save_signal;

    modport master (
        output raw_valid, raw_pad0, raw_pad1, raw_pad2, vs_n, save_ack,
        input  sensor_input, sensor_input_to_save, save_signal
    );

    modport slave (
        input  raw_valid, raw_pad0, raw_pad1, raw_pad2, vs_n, save_ack,
        output sensor_input, sensor_input_to_save, save_signal
    );

endinterface

// File: rtl/pad_avg_filter.sv
// One pad channel: moving average over 2^AVG_LOG2 samples, then noise floor and saturation.
module pad_avg_filter
    import pad_sensor_pkg::*;
#(
    parameter int                 AVG_LOG2    = 2,
    parameter logic [FIELD_W-1:0] NOISE_FLOOR = 7'd3,
    parameter logic [FIELD_W-1:0] SAT_MAX     = 7'd119
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    input  logic [FIELD_W-1:0] sample_i,
    output logic [FIELD_W-1:0] value_o
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SUM_W = FIELD_W + AVG_LOG2;

    logic [FIELD_W-1:0] hist_q [DEPTH];
    logic [FIELD_W-1:0] hist_d [DEPTH];
    logic [SUM_W-1:0]   sum_q;
    logic [SUM_W-1:0]   sum_d;
    logic [FIELD_W-1:0] avg;
    logic [FIELD_W-1:0] value_q;
    logic [FIELD_W-1:0] value_d;

    always_comb begin
        hist_d = hist_q;
        sum_d  = sum_q;
        if (valid_i) begin
            // Intermediate may exceed SUM_W, but the final sum always fits, so modular math is exact.
            sum_d     = sum_q + SUM_W'(sample_i) - SUM_W'(hist_q[DEPTH-1]);
            hist_d[0] = sample_i;
            for (int i = 1; i < DEPTH; i++) begin
                hist_d[i] = hist_q[i-1];
            end
        end
    end

    assign avg = FIELD_W'(sum_q >> AVG_LOG2);

    always_comb begin
        value_d = avg;
        if (avg < NOISE_FLOOR) begin
            value_d = '0;
        end else if (avg > SAT_MAX) begin
            value_d = SAT_MAX;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                hist_q[i] <= '0;
            end
            sum_q   <= '0;
            value_q <= '0;
        end else begin
            hist_q  <= hist_d;
            sum_q   <= sum_d;
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/pad_sensor_frontend.sv
// Three filtered pad channels published once per frame at the vsync fall, plus a press-onset
// snapshot handed to the save path over a req/ack handshake.
module pad_sensor_frontend
    import pad_sensor_pkg::*;
#(
    parameter int                 AVG_LOG2    = 2,
    parameter logic [FIELD_W-1:0] NOISE_FLOOR = 7'd3,
    parameter logic [FIELD_W-1:0] SAT_MAX     = 7'd119
) (
    input  logic                  clock,
    input  logic                  reset,
    pad_sensor_frontend_if.slave  bus
);

    logic [FIELD_W-1:0] staged0;
    logic [FIELD_W-1:0] staged1;
    logic [FIELD_W-1:0] staged2;

    pad_avg_filter #(.AVG_LOG2(AVG_LOG2), .NOISE_FLOOR(NOISE_FLOOR), .SAT_MAX(SAT_MAX)) u_filt0 (
        .clk_i    (clock),
        .rst_i    (reset),
        .valid_i  (bus.raw_valid),
        .sample_i (bus.raw_pad0),
        .value_o  (staged0)
    );

    pad_avg_filter #(.AVG_LOG2(AVG_LOG2), .NOISE_FLOOR(NOISE_FLOOR), .SAT_MAX(SAT_MAX)) u_filt1 (
        .clk_i    (clock),
        .rst_i    (reset),
        .valid_i  (bus.raw_valid),
        .sample_i (bus.raw_pad1),
        .value_o  (staged1)
    );

    pad_avg_filter #(.AVG_LOG2(AVG_LOG2), .NOISE_FLOOR(NOISE_FLOOR), .SAT_MAX(SAT_MAX)) u_filt2 (
        .clk_i    (clock),
        .rst_i    (reset),
        .valid_i  (bus.raw_valid),
        .sample_i (bus.raw_pad2),
        .value_o  (staged2)
    );

    logic        vs_n_q;
    logic        frame_edge;
    logic [31:0] pub_q;
    logic        pub_evt_q;
    logic        prev_zero_q;

    assign frame_edge = vs_n_q & ~bus.vs_n;

    // The staged registers update on the same edge, so a coincident update publishes the old value.
    always_ff @(posedge clock) begin
        if (reset) begin
            vs_n_q      <= 1'b1;
            pub_q       <= '0;
            pub_evt_q   <= 1'b0;
            prev_zero_q <= 1'b1;
        end else begin
            vs_n_q    <= bus.vs_n;
            pub_evt_q <= frame_edge;
            if (frame_edge) begin
                pub_q       <= pack_pads(staged0, staged1, staged2);
                prev_zero_q <= fields_all_zero(pub_q);
            end
        end
    end

    save_state_e state_q;
    save_state_e state_d;
    logic [31:0] snap_q;
    logic [31:0] snap_d;
    logic        req_q;
    logic        req_d;
    logic        onset;

    assign onset = pub_evt_q & prev_zero_q & ~fields_all_zero(pub_q);

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        req_d   = req_q;
        unique case (state_q)
            IDLE: begin
                if (onset) begin
                    snap_d  = pub_q;
                    req_d   = 1'b1;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (bus.save_ack) begin
                    req_d   = 1'b0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (fields_all_zero(pub_q)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            snap_q  <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            req_q   <= req_d;
        end
    end

    assign bus.sensor_input         = pub_q;
    assign bus.sensor_input_to_save = snap_q;
    assign bus.save_signal          = {31'b0, req_q};

endmodule

// File: tb/tb_pad_sensor_frontend.sv
// Directed bench for pad_sensor_frontend: filter, floor/saturation, frame alignment, save handshake.
module tb_pad_sensor_frontend;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    pad_sensor_frontend_if bus();

    pad_sensor_frontend dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic feed(input logic [6:0] a, input logic [6:0] b, input logic [6:0] c, input int n);
        for (int i = 0; i < n; i++) begin
            bus.raw_valid = 1'b1;
            bus.raw_pad0  = a;
            bus.raw_pad1  = b;
            bus.raw_pad2  = c;
            tick();
        end
        bus.raw_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic frame();
        bus.vs_n = 1'b0;
        tick();
        bus.vs_n = 1'b1;
        tick();
    endtask

    task automatic ack_pulse();
        bus.save_ack = 1'b1;
        tick();
        bus.save_ack = 1'b0;
        tick();
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        reset         = 1'b0;
        bus.raw_valid = 1'b1;
        bus.raw_pad0  = 7'h55;
        bus.raw_pad1  = 7'h2a;
        bus.raw_pad2  = 7'h7f;
        bus.vs_n      = 1'b1;
        bus.save_ack  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.vs_n = ~bus.vs_n;
            tick();
        end

        // 1: single-cycle reset clears everything
        reset = 1'b1;
        tick();
        reset         = 1'b0;
        bus.raw_valid = 1'b0;
        bus.vs_n      = 1'b1;
        bus.save_ack  = 1'b0;
        tick();
        chk("rst_sensor", bus.sensor_input, 32'd0);
        chk("rst_to_save", bus.sensor_input_to_save, 32'd0);
        chk("rst_save_sig", bus.save_signal, 32'd0);

        // 2: warm-up then full window; first nonzero publish is an onset
        feed(7'd40, 7'd0, 7'd0, 2);
        frame();
        chk("warmup_20", bus.sensor_input, 32'd20);
        chk("onset_warm_req", bus.save_signal, 32'd1);
        chk("onset_warm_snap", bus.sensor_input_to_save, 32'd20);
        ack_pulse();
        chk("ack_drop", bus.save_signal, 32'd0);
        feed(7'd40, 7'd0, 7'd0, 2);
        frame();
        chk("filter_40", bus.sensor_input, 32'd40);
        chk("held_no_req", bus.save_signal, 32'd0);

        // 3: noise floor on pad1, saturation on pad2
        feed(7'd40, 7'd2, 7'd127, 4);
        frame();
        chk("floor_sat", bus.sensor_input, 32'd1949736);

        // 4: frame alignment
        feed(7'd12, 7'd12, 7'd12, 4);
        chk("midframe_hold", bus.sensor_input, 32'd1949736);
        frame();
        chk("frame_12s", bus.sensor_input, 32'd198156);
        bus.raw_valid = 1'b1;
        bus.raw_pad0  = 7'd52;
        bus.raw_pad1  = 7'd12;
        bus.raw_pad2  = 7'd12;
        tick();
        bus.raw_valid = 1'b0;
        bus.vs_n      = 1'b0;
        tick();
        bus.vs_n = 1'b1;
        tick();
        chk("coincident_old", bus.sensor_input, 32'd198156);
        frame();
        chk("next_frame_new", bus.sensor_input, 32'd198166);

        // 5: save handshake
        feed(7'd0, 7'd0, 7'd0, 4);
        frame();
        chk("released_zero", bus.sensor_input, 32'd0);
        feed(7'd60, 7'd0, 7'd0, 4);
        frame();
        chk("onset60_sensor", bus.sensor_input, 32'd60);
        chk("onset60_req", bus.save_signal, 32'd1);
        chk("onset60_snap", bus.sensor_input_to_save, 32'd60);
        repeat (100) tick();
        chk("wait_req", bus.save_signal, 32'd1);
        chk("wait_snap", bus.sensor_input_to_save, 32'd60);
        feed(7'd80, 7'd0, 7'd0, 4);
        frame();
        chk("wait_sensor80", bus.sensor_input, 32'd80);
        chk("wait_snap_stable", bus.sensor_input_to_save, 32'd60);
        chk("wait_req_stable", bus.save_signal, 32'd1);
        ack_pulse();
        chk("ack60_drop", bus.save_signal, 32'd0);
        frame();
        chk("held_no_rereq", bus.save_signal, 32'd0);
        feed(7'd0, 7'd0, 7'd0, 4);
        frame();
        feed(7'd60, 7'd0, 7'd0, 4);
        frame();
        chk("repress_req", bus.save_signal, 32'd1);
        chk("repress_snap", bus.sensor_input_to_save, 32'd60);

        // 6: reset while waiting for ack, then normal re-request
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_wait_req", bus.save_signal, 32'd0);
        chk("rst_wait_sensor", bus.sensor_input, 32'd0);
        chk("rst_wait_snap", bus.sensor_input_to_save, 32'd0);
        ack_pulse();
        feed(7'd60, 7'd3, 7'd120, 4);
        frame();
        chk("post_rst_sensor", bus.sensor_input, 32'd1950140);
        chk("post_rst_req", bus.save_signal, 32'd1);
        chk("post_rst_snap", bus.sensor_input_to_save, 32'd1950140);
        ack_pulse();
        chk("post_rst_ack", bus.save_signal, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
